// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: folds the CPU's instruction and data SRAM-like ports onto
// one single-beat AXI3 master. One transaction in flight at a time; the data
// port wins when both ports request together.
// Optional feature macro: SRAM_AXI_BRIDGE_RDATA_BYPASS_EN (completion in the
// rvalid/bvalid cycle instead of one cycle later).
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    // instruction port
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AXI read address / data
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address / data / response
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} state_t;

    state_t      state_q;
    logic [31:0] addr_q, wdata_q, inst_rdata_q, data_rdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q, arid_q;
    logic        src_q;  // 1 = data port owns the transaction
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic        inst_ok_q, data_ok_q;

    logic        accept, sel_src, sel_wr;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        aw_done, w_done;

    // Arbitration and byte-lane decode of the request being accepted.
    always_comb begin
        data_addr_ok = (state_q == S_IDLE) && !reset && data_req;
        inst_addr_ok = (state_q == S_IDLE) && !reset && inst_req && !data_req;
        accept       = data_addr_ok || inst_addr_ok;
        sel_src      = data_req;
        sel_wr       = data_req ? data_wr    : inst_wr;
        sel_addr     = data_req ? data_addr  : inst_addr;
        sel_wdata    = data_req ? data_wdata : inst_wdata;
        // size 3 is carried as a word from here on
        sel_size     = data_req ? data_size  : inst_size;
        if (sel_size == 2'b11) sel_size = 2'b10;
        case (sel_size)
            2'b00:   sel_wstrb = 4'b0001 << sel_addr[1:0];
            2'b01:   sel_wstrb = sel_addr[1] ? 4'b1100 : 4'b0011;
            default: sel_wstrb = 4'b1111;
        endcase
        // an AW/W channel counts as done once it has handshaken, including this cycle
        aw_done = !awvalid_q || awready;
        w_done  = !wvalid_q  || wready;
    end

    // Transaction FSM with registered handshake outputs and completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            wstrb_q      <= '0;
            arid_q       <= '0;
            src_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        size_q  <= sel_size;
                        wstrb_q <= sel_wstrb;
                        src_q   <= sel_src;
                        arid_q  <= sel_src ? DATA_ID : INST_ID;
                        if (sel_wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_AWW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= S_IDLE;
                        if (src_q) data_rdata_q <= rdata;
                        else       inst_rdata_q <= rdata;
`ifndef SRAM_AXI_BRIDGE_RDATA_BYPASS_EN
                        data_ok_q <= src_q;
                        inst_ok_q <= !src_q;
`endif
                    end
                end
                S_AWW: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= S_IDLE;
`ifndef SRAM_AXI_BRIDGE_RDATA_BYPASS_EN
                        data_ok_q <= src_q;
                        inst_ok_q <= !src_q;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SRAM_AXI_BRIDGE_RDATA_BYPASS_EN
    logic r_beat, b_beat;
    // Completion is reported in the beat cycle itself.
    always_comb begin
        r_beat       = (state_q == S_R) && rvalid;
        b_beat       = (state_q == S_B) && bvalid;
        inst_data_ok = (r_beat || b_beat) && !src_q;
        data_data_ok = (r_beat || b_beat) && src_q;
        inst_rdata   = (r_beat && !src_q) ? rdata : inst_rdata_q;
        data_rdata   = (r_beat && src_q)  ? rdata : data_rdata_q;
    end
`else
    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
`endif

    assign arid    = arid_q;
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

    // rid is deliberately not checked: only one read is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^rid;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a completion scoreboard.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        src;   // 1 = data port
        logic        wr;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected completion and compare it with the ok/rdata outputs.
    task automatic check_done();
        exp_t e;
        chk("sb_has_entry", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("inst_data_ok", inst_data_ok, !e.src);
            chk("data_data_ok", data_data_ok, e.src);
            if (!e.wr) chk(e.src ? "data_rdata" : "inst_rdata", e.src ? data_rdata : inst_rdata, e.data);
            $display("done src=%0d wr=%0d data=%h", e.src, e.wr, e.data);
        end
    endtask

    task automatic serve_ar(input logic [31:0] a, input logic [3:0] id, input logic [2:0] sz);
        int n = 0;
        while (!arvalid && n < 20) begin cyc(); n++; end
        chk("arvalid_seen", arvalid, 1);
        chk("araddr", araddr, a);
        chk("arid", arid, id);
        chk("arsize", arsize, sz);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 0);
    endtask

    task automatic serve_r(input logic [31:0] d);
        int n = 0;
        while (!rready && n < 20) begin cyc(); n++; end
        chk("rready_seen", rready, 1);
        rvalid = 1'b1;
        rdata  = d;
        #1;
`ifdef SRAM_AXI_BRIDGE_RDATA_BYPASS_EN
        check_done();
        cyc();
        rvalid = 1'b0;
        #1;
`else
        chk("r_ok_early", 32'(inst_data_ok | data_data_ok), 0);
        cyc();
        rvalid = 1'b0;
        #1;
        check_done();
`endif
        chk("rready_drop", rready, 0);
    endtask

    task automatic serve_b();
        int n = 0;
        while (!bready && n < 20) begin cyc(); n++; end
        chk("bready_seen", bready, 1);
        bvalid = 1'b1;
        #1;
`ifdef SRAM_AXI_BRIDGE_RDATA_BYPASS_EN
        check_done();
        cyc();
        bvalid = 1'b0;
        #1;
`else
        chk("b_ok_early", 32'(inst_data_ok | data_data_ok), 0);
        cyc();
        bvalid = 1'b0;
        #1;
        check_done();
`endif
        chk("bready_drop", bready, 0);
    endtask

    // Present a data-port request in IDLE, expect immediate accept, record it.
    task automatic req_data(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd_exp);
        exp_t e;
        data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
        #1;
        chk("data_addr_ok", data_addr_ok, 1);
        e.src = 1'b1; e.wr = wr; e.data = rd_exp;
        sbq.push_back(e);
        cyc();
        data_req = 1'b0;
        #1;
        chk("addr_ok_busy", data_addr_ok, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 1; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;

        // Reset state: all outputs low, even with a request pending.
        cyc(); cyc();
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_ok", 32'(inst_data_ok | data_data_ok), 0);
        chk("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 0);
        chk("rst_rdata", inst_rdata | data_rdata, 0);
        chk("rst_payload", araddr | awaddr | wdata | 32'(arid) | 32'(wstrb), 0);
        data_req = 0;
        reset = 0;
        cyc();

        // 1: instruction word read.
        inst_req = 1; inst_addr = 32'h1FC0_0000; inst_size = 2;
        #1;
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_data_addr_ok", data_addr_ok, 0);
        e.src = 0; e.wr = 0; e.data = 32'hDEAD_BEEF;
        sbq.push_back(e);
        cyc();
        inst_req = 0;
        chk("t1_arvalid_t1", arvalid, 1);
        serve_ar(32'h1FC0_0000, 4'd0, 3'b010);
        serve_r(32'hDEAD_BEEF);
        cyc();
        chk("t1_pulse_single", 32'(inst_data_ok | data_data_ok), 0);

        // 2: simultaneous requests, data port first.
        inst_req = 1; inst_addr = 32'h1FC0_0040; inst_size = 2;
        data_req = 1; data_wr = 0; data_addr = 32'h0000_1000; data_size = 2;
        #1;
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_addr_ok, 0);
        e.src = 1; e.wr = 0; e.data = 32'h1111_2222;
        sbq.push_back(e);
        cyc();
        data_req = 0;
        #1;
        chk("t2_inst_blocked", inst_addr_ok, 0);
        serve_ar(32'h0000_1000, 4'd1, 3'b010);
        serve_r(32'h1111_2222);
        chk("t2_inst_addr_ok_after", inst_addr_ok, 1);
        e.src = 0; e.wr = 0; e.data = 32'h3333_4444;
        sbq.push_back(e);
        cyc();
        inst_req = 0;
        serve_ar(32'h1FC0_0040, 4'd0, 3'b010);
        serve_r(32'h3333_4444);
        cyc();

        // 3: byte store, W accepted at once, AW after three cycles.
        req_data(1, 2'd0, 32'h0000_2003, 32'hAB00_0000, 0);
        chk("t3_wstrb", wstrb, 4'b1000);
        chk("t3_awaddr", awaddr, 32'h0000_2003);
        chk("t3_awsize", awsize, 0);
        chk("t3_wdata", wdata, 32'hAB00_0000);
        chk("t3_wvalid", wvalid, 1);
        wready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_awvalid_hold", awvalid, 1);
            if (k == 3) awready = 1;
            cyc();
            wready = 0;
            if (k == 0) chk("t3_wvalid_drop", wvalid, 0);
        end
        awready = 0;
        chk("t3_awvalid_drop", awvalid, 0);
        chk("t3_bready", bready, 1);
        serve_b();
        cyc();

        // 4: halfword store, AW and W in the same cycle.
        req_data(1, 2'd1, 32'h0000_2002, 32'h5566_0000, 0);
        chk("t4_wstrb", wstrb, 4'b1100);
        chk("t4_awsize", awsize, 1);
        awready = 1; wready = 1;
        cyc();
        awready = 0; wready = 0;
        chk("t4_aw_w_drop", 32'({awvalid, wvalid}), 0);
        chk("t4_bready_next", bready, 1);
        serve_b();
        cyc();

        // Extra lanes: byte at offset 1, size 3 store, size 3 read.
        req_data(1, 2'd0, 32'h0000_2001, 32'h0000_CD00, 0);
        chk("x_wstrb_b1", wstrb, 4'b0010);
        awready = 1; wready = 1; cyc(); awready = 0; wready = 0;
        serve_b();
        cyc();
        req_data(1, 2'd3, 32'h0000_4001, 32'h0102_0304, 0);
        chk("x_wstrb_s3", wstrb, 4'b1111);
        chk("x_awsize_s3", awsize, 3'b010);
        wready = 1; cyc(); wready = 0;
        chk("x_aw_pending", awvalid, 1);
        awready = 1; cyc(); awready = 0;
        serve_b();
        cyc();
        req_data(0, 2'd3, 32'h0000_5000, 0, 32'h5A5A_A5A5);
        serve_ar(32'h0000_5000, 4'd1, 3'b010);
        serve_r(32'h5A5A_A5A5);
        cyc();

        // 5: reset while in R drops the read with no completion.
        req_data(0, 2'd2, 32'h0000_3000, 0, 0);
        serve_ar(32'h0000_3000, 4'd1, 3'b010);
        chk("t5_rready", rready, 1);
        void'(sbq.pop_back());
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_3100;
        reset = 1;
        #1;
        chk("t5_rready_rst", rready, 0);
        chk("t5_arvalid_rst", arvalid, 0);
        chk("t5_ok_rst", 32'({inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}), 0);
        cyc();
        reset = 0;
        req_data(0, 2'd2, 32'h0000_3100, 0, 32'hCAFE_F00D);
        serve_ar(32'h0000_3100, 4'd1, 3'b010);
        serve_r(32'hCAFE_F00D);
        n = 0;
        cyc();
        chk("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
